// File: rtl/logo_position_ctrl.sv
// Turns joystick ADC samples into a once-per-frame logo offset. The offset is updated only in vertical blanking.
// Build option LOGO_WRAP_EN: an offset that runs past the limit wraps to the opposite limit instead of saturating.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT    | idle, outputs held, waiting for col==0 && row==V_VIS
// CAPTURE | register both joystick samples
// COMPUTE | turn the samples into signed per-frame steps
// APPLY   | write the offsets (or recentre), pulse pos_update
module logo_position_ctrl #(
   parameter int JS_CENTRE  = 2048,
   parameter int DEADZONE   = 256,
   parameter int STEP_SHIFT = 7,
   parameter int MAX_STEP   = 8,
   parameter int C_LIM      = 256,
   parameter int R_LIM      = 176,
   parameter int V_VIS      = 480
) (
   input  logic        vga_clk,
   input  logic        arst_n,
   input  logic [11:0] joystick_data_x,
   input  logic [11:0] joystick_data_y,
   input  logic        js_button_f_d,
   input  logic [9:0]  col,
   input  logic [8:0]  row,
   output logic [9:0]  stick_border_hl_c,
   output logic [8:0]  stick_border_hl_r,
   output logic        pos_update
);

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_CAPTURE = 2'd1,
      S_COMPUTE = 2'd2,
      S_APPLY   = 2'd3
   } state_t;

   localparam logic [12:0]        JS_C13   = 13'(JS_CENTRE);
   localparam logic [12:0]        DZ13     = 13'(DEADZONE);
   localparam logic [12:0]        MAXS13   = 13'(MAX_STEP);
   localparam logic [3:0]         MAXS4    = 4'(MAX_STEP);
   localparam logic signed [10:0] C_LIM_S  = 11'(C_LIM);
   localparam logic signed [10:0] R_LIM_S  = 11'(R_LIM);
   localparam logic [8:0]         V_VIS9   = 9'(V_VIS);

   state_t              state;
   logic [11:0]         samp_x;
   logic [11:0]         samp_y;
   logic signed [10:0]  step_c;
   logic signed [10:0]  step_r;
   logic signed [10:0]  off_c;
   logic signed [10:0]  off_r;
   logic                recentre_pend;

   logic                trigger;
   logic [3:0]          mag_x;
   logic [3:0]          mag_y;
   logic                neg_x;
   logic                neg_y;
   logic signed [10:0]  sum_c;
   logic signed [10:0]  sum_r;
   logic signed [10:0]  next_c;
   logic signed [10:0]  next_r;

   // Magnitude of the per-frame step for one axis, before the sign is applied.
   function automatic logic [3:0] step_mag(input logic [11:0] sample);
      logic [12:0] d;
      logic [12:0] mag;
      logic [12:0] excess;
      logic [12:0] sh;
      d      = {1'b0, sample} - JS_C13;
      mag    = d[12] ? (~d + 13'd1) : d;
      excess = mag - DZ13;
      sh     = (excess >> STEP_SHIFT) + 13'd1;
      if (mag <= DZ13)
         return 4'd0;
      else if (sh > MAXS13)
         return MAXS4;
      else
         return sh[3:0];
   endfunction

   function automatic logic sample_neg(input logic [11:0] sample);
      logic [12:0] d;
      d = {1'b0, sample} - JS_C13;
      return d[12];
   endfunction

   function automatic logic signed [10:0] limit(input logic signed [10:0] v,
                                                input logic signed [10:0] lim);
`ifdef LOGO_WRAP_EN
      if (v > lim)
         return -lim;
      else if (v < -lim)
         return lim;
      else
         return v;
`else
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
`endif
   endfunction

   assign trigger = (col == 10'd0) && (row == V_VIS9);

   always_comb begin
      mag_x  = step_mag(samp_x);
      mag_y  = step_mag(samp_y);
      neg_x  = sample_neg(samp_x);
      neg_y  = sample_neg(samp_y);
      // Offsets are kept one bit wider than the ports so the sum cannot overflow before limiting.
      sum_c  = off_c + step_c;
      sum_r  = off_r + step_r;
      next_c = limit(sum_c, C_LIM_S);
      next_r = limit(sum_r, R_LIM_S);
   end

   always_ff @(posedge vga_clk) begin
      if (!arst_n) begin
         state         <= S_WAIT;
         samp_x        <= '0;
         samp_y        <= '0;
         step_c        <= '0;
         step_r        <= '0;
         off_c         <= '0;
         off_r         <= '0;
         pos_update    <= 1'b0;
         recentre_pend <= 1'b0;
      end else begin
         pos_update <= 1'b0;
         if (js_button_f_d)
            recentre_pend <= 1'b1;
         case (state)
            S_WAIT: begin
               if (trigger)
                  state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               samp_x <= joystick_data_x;
               samp_y <= joystick_data_y;
               state  <= S_COMPUTE;
            end
            S_COMPUTE: begin
               step_c <= neg_x ? -$signed({7'd0, mag_x}) : $signed({7'd0, mag_x});
               // Stick up (positive d) moves the logo up the screen, i.e. toward negative rows.
               step_r <= neg_y ? $signed({7'd0, mag_y}) : -$signed({7'd0, mag_y});
               state  <= S_APPLY;
            end
            S_APPLY: begin
               if (recentre_pend) begin
                  off_c <= '0;
                  off_r <= '0;
               end else begin
                  off_c <= next_c;
                  off_r <= next_r;
               end
               // A press landing on this very cycle belongs to the next frame.
               recentre_pend <= js_button_f_d;
               pos_update    <= 1'b1;
               state         <= S_WAIT;
            end
            default: state <= S_WAIT;
         endcase
      end
   end

   assign stick_border_hl_c = off_c[9:0];
   assign stick_border_hl_r = off_r[8:0];

endmodule

// File: tb/tb_logo_position_ctrl.sv
// Scoreboard bench for logo_position_ctrl: each frame pushes the modelled offsets, each pos_update pops and compares.
module tb_logo_position_ctrl;

   logic        vga_clk = 1'b0;
   logic        arst_n  = 1'b0;
   logic [11:0] joystick_data_x = 12'd2048;
   logic [11:0] joystick_data_y = 12'd2048;
   logic        js_button_f_d = 1'b0;
   logic [9:0]  col = 10'd5;
   logic [8:0]  row = 9'd0;
   logic [9:0]  stick_border_hl_c;
   logic [8:0]  stick_border_hl_r;
   logic        pos_update;

   typedef struct {
      int c;
      int r;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_c = 0;
   int   m_r = 0;
   bit   m_pend = 1'b0;
   bit   prev_pu = 1'b0;

   logo_position_ctrl dut (
      .vga_clk           (vga_clk),
      .arst_n            (arst_n),
      .joystick_data_x   (joystick_data_x),
      .joystick_data_y   (joystick_data_y),
      .js_button_f_d     (js_button_f_d),
      .col               (col),
      .row               (row),
      .stick_border_hl_c (stick_border_hl_c),
      .stick_border_hl_r (stick_border_hl_r),
      .pos_update        (pos_update)
   );

   always #20 vga_clk = ~vga_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int step_of(input int sample);
      int d;
      int a;
      int s;
      d = sample - 2048;
      a = (d < 0) ? -d : d;
      if (a <= 256) return 0;
      s = ((a - 256) / 128) + 1;
      if (s > 8) s = 8;
      return (d < 0) ? -s : s;
   endfunction

   function automatic int lim(input int v, input int l);
`ifdef LOGO_WRAP_EN
      if (v > l) return -l;
      if (v < -l) return l;
      return v;
`else
      if (v > l) return l;
      if (v < -l) return -l;
      return v;
`endif
   endfunction

   function automatic int out_c();
      int v;
      v = $signed(stick_border_hl_c);
      return v;
   endfunction

   function automatic int out_r();
      int v;
      v = $signed(stick_border_hl_r);
      return v;
   endfunction

   always @(negedge vga_clk) begin
      exp_t e;
      if (pos_update) begin
         if (prev_pu)
            check("pu_width", 2, 1);
         if (sb.size() == 0) begin
            check("unexpected_pu", 1, 0);
         end else begin
            e = sb.pop_front();
            check("off_c", out_c(), e.c);
            check("off_r", out_r(), e.r);
         end
      end
      prev_pu = pos_update;
   end

   task automatic do_reset();
      @(negedge vga_clk);
      arst_n = 1'b0;
      repeat (2) @(negedge vga_clk);
      arst_n = 1'b1;
      m_c = 0;
      m_r = 0;
      m_pend = 1'b0;
   endtask

   // One frame: trigger held for trig_len cycles; btn_apply pulses the button on the APPLY edge.
   task automatic do_frame(input int trig_len, input bit btn_apply);
      exp_t e;
      int   seen;
      if (m_pend) begin
         m_c = 0;
         m_r = 0;
      end else begin
         m_c = lim(m_c + step_of(int'(joystick_data_x)), 256);
         m_r = lim(m_r - step_of(int'(joystick_data_y)), 176);
      end
      m_pend = btn_apply;
      e.c = m_c;
      e.r = m_r;
      sb.push_back(e);
      @(negedge vga_clk);
      col = 10'd0;
      row = 9'd480;
      @(negedge vga_clk);
      if (trig_len <= 1) begin
         col = 10'd5;
         row = 9'd0;
      end
      seen = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge vga_clk);
         if (pos_update && seen == 0) seen = k;
         if (k + 1 >= trig_len) begin
            col = 10'd5;
            row = 9'd0;
         end
         js_button_f_d = btn_apply && (k == 2);
      end
      js_button_f_d = 1'b0;
      check("latency", seen, 3);
   endtask

   task automatic pulse_btn();
      @(negedge vga_clk);
      js_button_f_d = 1'b1;
      @(negedge vga_clk);
      js_button_f_d = 1'b0;
      m_pend = 1'b1;
   endtask

   initial begin
      do_reset();
      @(negedge vga_clk);
      check("rst_c", out_c(), 0);
      check("rst_r", out_r(), 0);
      check("rst_pu", int'(pos_update), 0);

      // Stick at rest: offsets stay centred.
      for (int i = 0; i < 3; i++) do_frame(1, 1'b0);

      // Full right: saturating climb to the column limit.
      joystick_data_x = 12'd4095;
      for (int i = 0; i < 42; i++) do_frame(1, 1'b0);
`ifndef LOGO_WRAP_EN
      check("c_sat", out_c(), 256);
`endif

      // Deadzone edges and smallest steps.
      do_reset();
      joystick_data_x = 12'd2400;
      for (int i = 0; i < 3; i++) do_frame(1, 1'b0);
      joystick_data_x = 12'd2304;
      for (int i = 0; i < 2; i++) do_frame(1, 1'b0);
      check("dz_hold", out_c(), 3);
      joystick_data_x = 12'd2305;
      do_frame(1, 1'b0);
      joystick_data_x = 12'd1696;
      do_frame(1, 1'b0);
      joystick_data_x = 12'd1792;
      do_frame(1, 1'b0);

      // Stick down: rows grow to the limit (or wrap).
      do_reset();
      joystick_data_x = 12'd2048;
      joystick_data_y = 12'd0;
      for (int i = 0; i < 24; i++) do_frame(1, 1'b0);

      // Recentre from c=+40 / r=-24.
      do_reset();
      joystick_data_x = 12'd4095;
      joystick_data_y = 12'd4095;
      for (int i = 0; i < 3; i++) do_frame(1, 1'b0);
      joystick_data_y = 12'd2048;
      for (int i = 0; i < 2; i++) do_frame(1, 1'b0);
      check("pre_rc_c", out_c(), 40);
      check("pre_rc_r", out_r(), -24);
      pulse_btn();
      do_frame(1, 1'b0);
      do_frame(1, 1'b0);

      // Press on the APPLY edge carries over to the following frame.
      do_frame(1, 1'b1);
      do_frame(1, 1'b0);
      do_frame(1, 1'b0);

      // Trigger held into CAPTURE/COMPUTE must not start a second update.
      do_frame(3, 1'b0);

      // Reset while the sequence is in flight.
      @(negedge vga_clk);
      col = 10'd0;
      row = 9'd480;
      @(negedge vga_clk);
      col = 10'd5;
      row = 9'd0;
      @(negedge vga_clk);
      arst_n = 1'b0;
      @(negedge vga_clk);
      arst_n = 1'b1;
      m_c = 0;
      m_r = 0;
      m_pend = 1'b0;
      repeat (6) @(negedge vga_clk);
      check("mid_rst_c", out_c(), 0);
      check("mid_rst_r", out_r(), 0);
      do_frame(1, 1'b0);
      check("post_rst_c", out_c(), 8);

      repeat (4) @(negedge vga_clk);
      check("sb_left", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
